// File: rtl/music_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : music_player                                                     |
// | Brief   : Steps through a synchronous note ROM and plays each word as a    |
// |           square-wave tone or rest until the end-of-song marker.           |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module music_player #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TICK_DIV   = 50000,
    parameter int HP_UNIT    = 1000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
    output logic                  beep_o,
    output logic [3:0]            note_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int c_cnt_max = (16 * TICK_DIV > 15 * HP_UNIT) ? 16 * TICK_DIV : 15 * HP_UNIT;
    localparam int c_cw      = $clog2(c_cnt_max + 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_decode = 3'd3;
    localparam logic [2:0] c_st_play   = 3'd4;
    localparam logic [2:0] c_st_done   = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_note;
    logic [c_cw-1:0]       r_dur_cnt;
    logic [c_cw-1:0]       r_tone_cnt;
    logic                  r_beep;
    logic [3:0]            r_note_out;
    logic                  r_busy;
    logic                  r_done;

    logic [c_cw-1:0]       w_note_len;
    logic [c_cw-1:0]       w_half;
    logic                  w_play_last;
    logic                  w_half_last;

    // Note length (D+1)*TICK_DIV and half period (16-P)*HP_UNIT from the latched word.
    assign w_note_len  = (c_cw'(r_note[3:0]) + c_cw'(1)) * c_cw'(TICK_DIV);
    assign w_half      = c_cw'(5'd16 - {1'b0, r_note[7:4]}) * c_cw'(HP_UNIT);
    assign w_play_last = (r_dur_cnt == w_note_len - c_cw'(1));
    assign w_half_last = (r_tone_cnt == w_half - c_cw'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_st_idle;
            r_addr     <= '0;
            r_note     <= '0;
            r_dur_cnt  <= '0;
            r_tone_cnt <= '0;
            r_beep     <= 1'b0;
            r_note_out <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (stop_i) begin
            r_state    <= c_st_idle;
            r_beep     <= 1'b0;
            r_note_out <= 4'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start_i) begin
                        r_state <= c_st_fetch;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_fetch: r_state <= c_st_wait;
                c_st_wait: begin
                    r_note  <= rom_data_i[7:0];
                    r_state <= c_st_decode;
                end
                c_st_decode: begin
                    if (r_note == 8'h00) begin
                        r_state <= c_st_done;
                        r_done  <= 1'b1;
                    end else begin
                        r_state    <= c_st_play;
                        r_dur_cnt  <= '0;
                        r_tone_cnt <= '0;
                        r_beep     <= 1'b0;
                        r_note_out <= r_note[7:4];
                    end
                end
                c_st_play: begin
                    if (w_play_last) begin
                        r_beep     <= 1'b0;
                        r_note_out <= 4'd0;
                        // The last address ends the song instead of wrapping.
                        if (r_addr == {ADDR_WIDTH{1'b1}}) begin
                            r_state <= c_st_done;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                            r_state <= c_st_fetch;
                        end
                    end else begin
                        r_dur_cnt <= r_dur_cnt + c_cw'(1);
                        if (r_note[7:4] != 4'd0) begin
                            if (w_half_last) begin
                                r_tone_cnt <= '0;
                                r_beep     <= ~r_beep;
                            end else begin
                                r_tone_cnt <= r_tone_cnt + c_cw'(1);
                            end
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_addr_o = r_addr;
    assign beep_o     = r_beep;
    assign note_o     = r_note_out;
    assign busy_o     = r_busy;
    assign done_o     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_music_player.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_music_player                                                  |
// | Brief   : Randomized self-checking bench for music_player against a        |
// |           song-level expected output trace.                                |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_music_player;

    localparam int c_tick = 4;
    localparam int c_hp   = 1;

    logic       clk;
    logic       rstn;
    logic       start_i;
    logic       stop_i;
    logic [1:0] rom_addr_o;
    logic [7:0] rom_data_i;
    logic       beep_o;
    logic [3:0] note_o;
    logic       busy_o;
    logic       done_o;

    logic [7:0] rom [4];
    logic [8:0] exp_q [$];
    int         n_checks;
    int         n_fail;

    music_player #(
        .ADDR_WIDTH (2),
        .DATA_WIDTH (8),
        .TICK_DIV   (c_tick),
        .HP_UNIT    (c_hp)
    ) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .rom_addr_o (rom_addr_o),
        .rom_data_i (rom_data_i),
        .beep_o     (beep_o),
        .note_o     (note_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] pack(input int a, input bit busy, input bit done,
                                        input bit beep, input int note);
        logic [31:0] av;
        logic [31:0] nv;
        av = a;
        nv = note;
        return {av[1:0], busy, done, beep, nv[3:0]};
    endfunction

    function automatic logic [31:0] observed();
        return {23'd0, rom_addr_o, busy_o, done_o, beep_o, note_o};
    endfunction

    // Expected per-cycle outputs of a whole song, starting the cycle after start.
    task automatic build_trace();
        exp_q.delete();
        for (int a = 0; a < 4; a++) begin
            int p;
            int d;
            for (int g = 0; g < 3; g++) exp_q.push_back(pack(a, 1, 0, 0, 0));
            if (rom[a] == 8'h00) begin
                exp_q.push_back(pack(a, 1, 1, 0, 0));
                exp_q.push_back(pack(a, 0, 0, 0, 0));
                return;
            end
            p = int'(rom[a][7:4]);
            d = int'(rom[a][3:0]);
            for (int k = 0; k < (d + 1) * c_tick; k++)
                exp_q.push_back(pack(a, 1, 0, (p != 0) && (((k / ((16 - p) * c_hp)) % 2) == 1), p));
            if (a == 3) begin
                exp_q.push_back(pack(a, 1, 1, 0, 0));
                exp_q.push_back(pack(a, 0, 0, 0, 0));
            end
        end
    endtask

    task automatic run_song(input string tag, input int dup_start);
        build_trace();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        foreach (exp_q[i]) begin
            check(tag, observed(), {23'd0, exp_q[i]});
            start_i = (i == dup_start);
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    task automatic check_quiet(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check(tag, {28'd0, busy_o, done_o, beep_o, |note_o}, 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        start_i  = 1'b0;
        stop_i   = 1'b0;
        rom      = '{8'h00, 8'h00, 8'h00, 8'h00};
        rstn     = 1'b1;
        #1 rstn  = 1'b0;
        #1 check("reset_state", observed(), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        rom = '{8'hF1, 8'h00, 8'h00, 8'h00};
        run_song("song_f1", -1);
        rom = '{8'h02, 8'h13, 8'h00, 8'h00};
        run_song("song_rest", -1);
        rom = '{8'h11, 8'h11, 8'h11, 8'h11};
        run_song("song_addr_max", -1);
        check_quiet("idle_after_max", 3);
        check("addr_held", {30'd0, rom_addr_o}, 32'd3);

        // start_i during playback must not disturb the sequence.
        rom = '{8'hA2, 8'h51, 8'h00, 8'h00};
        run_song("restart_ignored", 12);

        // stop_i five cycles into a note.
        rom = '{8'h35, 8'h00, 8'h00, 8'h00};
        build_trace();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            check("pre_stop", observed(), {23'd0, exp_q[i]});
            if (i < 8) @(negedge clk);
        end
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        check("after_stop", observed(), 32'd0);
        check_quiet("stop_quiet", 40);

        // Asynchronous reset in the middle of a tone while beep_o is high.
        rom = '{8'hF3, 8'h00, 8'h00, 8'h00};
        build_trace();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            check("pre_reset", observed(), {23'd0, exp_q[i]});
            if (i < 8) @(negedge clk);
        end
        #2 rstn = 1'b0;
        #1 check("async_reset", observed(), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        check_quiet("post_reset_idle", 20);
        check("post_reset_addr", {30'd0, rom_addr_o}, 32'd0);

        // start and stop together in IDLE.
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        check_quiet("start_stop_idle", 5);

        for (int n = 0; n < 8; n++) begin
            for (int a = 0; a < 4; a++) begin
                logic [3:0] p;
                logic [3:0] d;
                p = 4'($urandom_range(0, 15));
                d = 4'($urandom_range(0, 7));
                rom[a] = ($urandom_range(0, 4) == 0) ? 8'h00 : {p, d};
            end
            run_song("random_song", (n % 2 == 1) ? int'($urandom_range(0, 20)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
